bitcoin_hash_param: RTL

BITCOIN_HASH_PARAM -- requirements
Module: bitcoin_hash_param

---
 rtl/bitcoin_hash_param.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/bitcoin_hash_param.sv
// Bitcoin-style nonce search: double SHA-256 of an 80-byte header for a run of
// consecutive nonces. The first-block midstate is computed once per start, and
// each nonce costs 64 + 64 rounds plus the write and step cycles.
module bitcoin_hash_param #(
  parameter int          NUM_NONCES  = 16,
  parameter logic [31:0] NONCE_START = 32'h0000_0000,
  parameter int          OUT_WORDS   = 1,
  parameter int          EARLY_EXIT  = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [31:0] found_nonce,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_READ, S_BLK1, S_MID, S_BLK2, S_BLK3, S_WRITE, S_NEXT, S_DONE
  } state_t;
  typedef logic [7:0][31:0]  hash_t;  // [0] = a / H0
  typedef logic [15:0][31:0] win_t;   // [0] = W[t] of the current round

  localparam hash_t IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                          32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic hash_t sha_round(input hash_t v, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] t1, t2;
    t1 = v[7] + big_s1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k + w;
    t2 = big_s0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    return {v[6], v[5], v[4], v[3] + t1, v[2], v[1], v[0], t1 + t2};
  endfunction

  function automatic hash_t hash_add(input hash_t x, input hash_t y);
    hash_t r;
    for (int i = 0; i < 8; i++) r[i] = x[i] + y[i];
    return r;
  endfunction

  // Second block of the header: tail words, nonce, padding, length 640 bits.
  function automatic win_t blk2_sched(input logic [2:0][31:0] tl, input logic [31:0] n);
    return {32'd640, {10{32'h0}}, 32'h8000_0000, n, tl[2], tl[1], tl[0]};
  endfunction

  // Outer hash block: 256-bit first digest, padding, length 256 bits.
  function automatic win_t blk3_sched(input hash_t d);
    return {32'd256, {6{32'h0}}, 32'h8000_0000, d};
  endfunction

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [5:0]        rnd_q, rnd_d;
  logic [7:0]        idx_q, idx_d;
  logic [31:0]       nonce_q, nonce_d;
  win_t              win_q, win_d;
  logic [2:0][31:0]  tail_q, tail_d;
  hash_t             vars_q, vars_d;
  hash_t             mid_q, mid_d;
  hash_t             fin_q, fin_d;
  logic              found_q, found_d;
  logic [31:0]       fnonce_q, fnonce_d;

  hash_t       round_out, fin_calc, dig1_calc;
  logic [31:0] sched_new;
  win_t        win_shift;
  logic        last_nonce;
  logic [15:0] wr_off;

  assign round_out  = sha_round(vars_q, K_TAB[rnd_q], win_q[0]);
  assign sched_new  = small_s1(win_q[14]) + win_q[9] + small_s0(win_q[1]) + win_q[0];
  assign win_shift  = {sched_new, win_q[15:1]};
  assign fin_calc   = hash_add(IV, round_out);
  assign dig1_calc  = hash_add(mid_q, round_out);
  assign last_nonce = (idx_q == 8'(NUM_NONCES - 1)) || ((EARLY_EXIT != 0) && found_q);
  assign wr_off     = 16'(idx_q) * 16'(OUT_WORDS) + {11'd0, cnt_q};
  assign mem_clk    = clk;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rnd_q    <= '0;
      idx_q    <= '0;
      nonce_q  <= '0;
      win_q    <= '0;
      tail_q   <= '0;
      vars_q   <= '0;
      mid_q    <= '0;
      fin_q    <= '0;
      found_q  <= 1'b0;
      fnonce_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rnd_q    <= rnd_d;
      idx_q    <= idx_d;
      nonce_q  <= nonce_d;
      win_q    <= win_d;
      tail_q   <= tail_d;
      vars_q   <= vars_d;
      mid_q    <= mid_d;
      fin_q    <= fin_d;
      found_q  <= found_d;
      fnonce_q <= fnonce_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_READ;
      S_READ:  if (cnt_q == 5'd19) state_d = S_BLK1;
      S_BLK1:  if (rnd_q == 6'd63) state_d = S_MID;
      S_MID:   state_d = S_BLK2;
      S_BLK2:  if (rnd_q == 6'd63) state_d = S_BLK3;
      S_BLK3:  if (rnd_q == 6'd63) state_d = S_WRITE;
      S_WRITE: if (cnt_q == 5'(OUT_WORDS - 1)) state_d = S_NEXT;
      S_NEXT:  state_d = last_nonce ? S_DONE : S_BLK2;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: header fetch, round engine, block hand-offs, result capture.
  always_comb begin
    cnt_d    = cnt_q;
    rnd_d    = rnd_q;
    idx_d    = idx_q;
    nonce_d  = nonce_q;
    win_d    = win_q;
    tail_d   = tail_q;
    vars_d   = vars_q;
    mid_d    = mid_q;
    fin_d    = fin_q;
    found_d  = found_q;
    fnonce_d = fnonce_q;
    case (state_q)
      S_IDLE: if (start) begin
        cnt_d    = '0;
        rnd_d    = '0;
        idx_d    = '0;
        nonce_d  = NONCE_START;
        found_d  = 1'b0;
        fnonce_d = '0;
      end
      S_READ: begin
        // Read data lags the address by one cycle, so word cnt-1 arrives now.
        cnt_d = cnt_q + 5'd1;
        if (cnt_q != 5'd0) begin
          if (cnt_q <= 5'd16) win_d = {mem_read_data, win_q[15:1]};
          else                tail_d = {mem_read_data, tail_q[2:1]};
        end
        if (cnt_q == 5'd19) begin
          cnt_d  = '0;
          rnd_d  = '0;
          vars_d = IV;
        end
      end
      S_BLK1: begin
        vars_d = round_out;
        win_d  = win_shift;
        rnd_d  = rnd_q + 6'd1;
      end
      S_MID: begin
        mid_d  = hash_add(IV, vars_q);
        vars_d = hash_add(IV, vars_q);
        win_d  = blk2_sched(tail_q, nonce_q);
      end
      S_BLK2: begin
        vars_d = round_out;
        win_d  = win_shift;
        rnd_d  = rnd_q + 6'd1;
        if (rnd_q == 6'd63) begin
          vars_d = IV;
          win_d  = blk3_sched(dig1_calc);
        end
      end
      S_BLK3: begin
        vars_d = round_out;
        win_d  = win_shift;
        rnd_d  = rnd_q + 6'd1;
        if (rnd_q == 6'd63) begin
          fin_d = fin_calc;
          cnt_d = '0;
          if (!found_q && (fin_calc[0] < target)) begin
            found_d  = 1'b1;
            fnonce_d = nonce_q;
          end
        end
      end
      S_WRITE: begin
        cnt_d = (cnt_q == 5'(OUT_WORDS - 1)) ? 5'd0 : cnt_q + 5'd1;
      end
      S_NEXT: if (!last_nonce) begin
        idx_d   = idx_q + 8'd1;
        nonce_d = nonce_q + 32'd1;
        win_d   = blk2_sched(tail_q, nonce_q + 32'd1);
        vars_d  = mid_q;
      end
      default: ;
    endcase
  end

  // Outputs are decoded from registered state, so reset clears them at once.
  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    done           = (state_q == S_DONE);
    found          = found_q;
    found_nonce    = fnonce_q;
    case (state_q)
      S_READ:  mem_addr = message_addr + {11'd0, cnt_q};
      S_WRITE: begin
        mem_we         = 1'b1;
        mem_addr       = output_addr + wr_off;
        mem_write_data = fin_q[cnt_q[2:0]];
      end
      default: ;
    endcase
  end

endmodule
